// File: rtl/fp16_fxpn_mul_pipe.sv
// fp16_fxpn_mul_pipe
//   Multi-lane pipelined multiplier. Each lane multiplies a binary16 operand
//   by a signed fixed-point operand (value b * 2^-FXP_FRAC). The result is the
//   exact product rounded once to binary16 with round-to-nearest-even.
//   Subnormal inputs are read as zero. Results below 2^-14 flush to signed zero.
//
//   Three stages, all advancing together on adv = ~out_valid | out_ready:
//     S1 unpack / |b| / classify
//     S2 significand multiply / exponent bias
//     S3 normalise / round / pack into the output register
//
//   Ports
//     clk        clock, rising edge
//     reset      synchronous active-high reset
//     in_valid   input beat valid (all lanes)
//     in_ready   beat accepted when in_valid & in_ready
//     a          LANES x fp16, lane i at a[16i +: 16]
//     b          LANES x signed fixed-point, lane i at b[FXP_WIDTH*i +: FXP_WIDTH]
//     out_valid  result beat valid
//     out_ready  beat consumed when out_valid & out_ready
//     result     LANES x fp16, packed like a
//
//   Build option
//     FP16_FXP_MUL_SATURATE_EN  overflow gives +-65504 instead of +-Inf

module fp16_fxpn_mul_pipe #(
  parameter int FXP_WIDTH = 8,
  parameter int FXP_FRAC  = 0,
  parameter int LANES     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*LANES-1:0]        a,
  input  logic [FXP_WIDTH*LANES-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*LANES-1:0]        result
);

  localparam int PW = 11 + FXP_WIDTH;

  localparam logic [1:0] CLS_NUM  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  logic adv;
  logic s1_valid;
  logic s2_valid;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane

    // ---------------- S1: unpack and classify ----------------
    logic [15:0]          av;
    logic [FXP_WIDTH-1:0] bv;
    logic                 a_sign;
    logic [4:0]           a_exp;
    logic [9:0]           a_man;
    logic                 b_sign;
    logic                 b_zero;
    logic [FXP_WIDTH-1:0] b_mag;
    logic [1:0]           cls_d;

    assign av     = a[16*i +: 16];
    assign bv     = b[FXP_WIDTH*i +: FXP_WIDTH];
    assign a_sign = av[15];
    assign a_exp  = av[14:10];
    assign a_man  = av[9:0];
    assign b_sign = bv[FXP_WIDTH-1];
    assign b_zero = ~|bv;
    // Unsigned magnitude keeps -2^(FXP_WIDTH-1) exact.
    assign b_mag  = b_sign ? (~bv + 1'b1) : bv;

    always_comb begin
      cls_d = CLS_NUM;
      if (a_exp == 5'h1f && |a_man)
        cls_d = CLS_NAN;
      else if (a_exp == 5'h1f)
        cls_d = b_zero ? CLS_NAN : CLS_INF;
      else if (a_exp == 5'h00 || b_zero)
        cls_d = CLS_ZERO;
    end

    logic                 s1_sign;
    logic [4:0]           s1_exp;
    logic [10:0]          s1_ma;
    logic [FXP_WIDTH-1:0] s1_mb;
    logic [1:0]           s1_cls;

    always_ff @(posedge clk) begin
      if (adv && in_valid) begin
        s1_sign <= a_sign ^ b_sign;
        s1_exp  <= a_exp;
        s1_ma   <= {1'b1, a_man};
        s1_mb   <= b_mag;
        s1_cls  <= cls_d;
      end
    end

    // ---------------- S2: multiply and exponent bias ----------------
    logic              s2_sign;
    logic signed [7:0] s2_exp;
    logic [PW-1:0]     s2_prod;
    logic [1:0]        s2_cls;

    always_ff @(posedge clk) begin
      if (adv && s1_valid) begin
        s2_sign <= s1_sign;
        s2_exp  <= {3'b000, s1_exp} - 8'(FXP_FRAC);
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        s2_cls  <= s1_cls;
      end
    end

    // ---------------- S3: normalise, round, pack ----------------
    int          lead;
    int          e_res;
    logic [PW-1:0] norm;
    logic [10:0] sig;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [11:0] sum;
    logic [9:0]  frac;
    logic [15:0] ovf_val;
    logic [15:0] res_d;
    logic [15:0] res_q;

`ifdef FP16_FXP_MUL_SATURATE_EN
    assign ovf_val = {s2_sign, 15'h7BFF};
`else
    assign ovf_val = {s2_sign, 15'h7C00};
`endif

    always_comb begin
      lead = 0;
      for (int k = 0; k < PW; k++)
        if (s2_prod[k]) lead = k;
      // Leading one moved to the MSB; the 11 bits below it form the
      // significand, then guard, then everything else ORs into sticky.
      norm   = s2_prod << (PW - 1 - lead);
      sig    = norm[PW-1 -: 11];
      guard  = norm[PW-12];
      sticky = |norm[PW-13:0];
      rnd    = guard & (sticky | sig[0]);
      sum    = {1'b0, sig} + {11'd0, rnd};
      // Carry-out means the significand rounded up to 2.0: shift and bump.
      frac   = sum[11] ? sum[10:1] : sum[9:0];
      e_res  = int'(s2_exp) + lead - 10 + int'(sum[11]);

      res_d = {s2_sign, 15'd0};
      case (s2_cls)
        CLS_NAN:  res_d = 16'h7E00;
        CLS_INF:  res_d = {s2_sign, 15'h7C00};
        CLS_ZERO: res_d = {s2_sign, 15'd0};
        default: begin
          if (e_res > 30)
            res_d = ovf_val;
          else if (e_res < 1)
            res_d = {s2_sign, 15'd0};
          else
            res_d = {s2_sign, e_res[4:0], frac};
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset)
        res_q <= 16'd0;
      else if (adv && s2_valid)
        res_q <= res_d;
    end

    assign result[16*i +: 16] = res_q;
  end

endmodule

// File: tb/tb_fp16_fxpn_mul_pipe.sv
// Directed bench for fp16_fxpn_mul_pipe: a 4-lane default instance and a
// 2-lane instance with two fraction bits, driven on a shared clock.

module tb_fp16_fxpn_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] a2;
  logic [15:0] b2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] result2;

  int total = 0;
  int bad   = 0;

`ifdef FP16_FXP_MUL_SATURATE_EN
  localparam logic [15:0] OVF_P = 16'h7BFF;
  localparam logic [15:0] OVF_N = 16'hFBFF;
`else
  localparam logic [15:0] OVF_P = 16'h7C00;
  localparam logic [15:0] OVF_N = 16'hFC00;
`endif

  always #5 clk = ~clk;

  fp16_fxpn_mul_pipe #(.FXP_WIDTH(8), .FXP_FRAC(0), .LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  fp16_fxpn_mul_pipe #(.FXP_WIDTH(8), .FXP_FRAC(2), .LANES(2)) dut_frac (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .result    (result2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send1(input string tag, input logic [63:0] av, input logic [31:0] bv,
                       input logic [63:0] ev);
    int cnt;
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 3);
    chk({tag, "_result"}, result, ev);
    @(posedge clk); #1;
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask

  task automatic send2(input string tag, input logic [31:0] av, input logic [15:0] bv,
                       input logic [31:0] ev);
    int cnt;
    a2 = av; b2 = bv; in_valid2 = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready2, 1'b1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cnt = 1;
    while (!out_valid2 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 3);
    chk({tag, "_result"}, result2, ev);
  endtask

  initial begin
    logic [15:0] exp_stream [6];
    logic [63:0] held;
    logic [7:0]  bb;
    int prod, emit, stall, cyc;
    logic seen, acc;

    exp_stream[0] = 16'h3C00; exp_stream[1] = 16'h4000; exp_stream[2] = 16'h4200;
    exp_stream[3] = 16'h4400; exp_stream[4] = 16'h4500; exp_stream[5] = 16'h4600;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    send1("basic", {4{16'h3C00}}, 32'h03FF_0080,
          {16'h4200, 16'hBC00, 16'h0000, 16'hD800});
    send1("special1", {16'h3C01, 16'h7BFF, 16'h7E00, 16'h7C00}, 32'h0302_0100,
          {16'h4202, OVF_P, 16'h7E00, 16'h7E00});
    send1("special2", {16'hFC00, 16'h0001, 16'hC000, 16'h3C00}, 32'hFE05_037F,
          {16'h7C00, 16'h0000, 16'hC600, 16'h57F0});
    send1("signs", {16'h7BFF, 16'hC000, 16'h8000, 16'h0400}, 32'hFEFD_0301,
          {OVF_N, 16'h4600, 16'h8000, 16'h0400});
    send1("round", {16'h3C03, 16'h3C01, 16'h3D55, 16'h7BFF}, 32'h0307_03FF,
          {16'h4204, 16'h4702, 16'h4400, 16'hFBFF});

    send2("frac1", {16'h0400, 16'h4000}, 16'h0105, {16'h0000, 16'h4100});
    send2("frac2", {16'h3C00, 16'h0400}, 16'hFF04, {16'hB400, 16'h0400});

    // Back-to-back stream with a 5-cycle consumer stall on the first result.
    prod = 0; emit = 0; stall = 0; cyc = 0; seen = 1'b0; held = '0;
    out_ready = 1'b1;
    while (emit < 6 && cyc < 40) begin
      in_valid = (prod < 6);
      bb = 8'(prod + 1);
      a = {4{16'h3C00}};
      b = {4{bb}};
      #1;
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall = 5;
        held = result;
      end
      out_ready = (stall == 0);
      #1;
      chk("bp_in_ready", in_ready, stall == 0);
      if (stall > 0) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_result", result, held);
      end else if (out_valid) begin
        chk("bp_emit", result, {4{exp_stream[emit]}});
        emit++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) prod++;
      if (stall > 0) stall--;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_emit_count", emit, 6);
    chk("bp_accept_count", prod, 6);
    chk("bp_no_extra", out_valid, 1'b0);

    // Reset while two beats are in flight.
    a = {4{16'h3C00}}; b = {4{8'h05}}; in_valid = 1'b1;
    @(posedge clk); #1;
    b = {4{8'h06}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", out_valid, 1'b0);
    end
    send1("post_rst", {4{16'h3C00}}, {4{8'h02}}, {4{16'h4000}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_fxpn_mul_pipe.md
# fp16_fxpn_mul_pipe

Pipelined, multi-lane mixed-precision multiplier: each lane multiplies an IEEE-754 binary16 operand by a signed fixed-point operand of parametrised width and fraction and returns a binary16 product. It is the next generation of the single-lane fp16 × fxp8 multiplier and is used in the dequantise-and-scale path of the PE array, between the weight buffer and the fp16 accumulators. It adds lane parallelism, a fraction-bit parameter, a valid/ready handshake with full-pipeline stall, and a single correctly rounded result.

## Interface
- FXP_WIDTH, 8: width of each signed two's-complement fixed-point operand; legal range 2..12.
- FXP_FRAC, 0: fraction bits of the fixed-point operand, so its value is b·2^-FXP_FRAC; legal range 0..FXP_WIDTH-1.
- LANES, 4: number of independent multiplier lanes, legal ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid; one valid covers all lanes.
- in_ready  out  1  block accepts a beat on a cycle where in_valid & in_ready.
- a  in  16·LANES  fp16 operands; lane i is a[16i+15:16i].
- b  in  FXP_WIDTH·LANES  fixed-point operands; lane i is b[FXP_WIDTH·i+FXP_WIDTH-1 : FXP_WIDTH·i].
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts a beat on a cycle where out_valid & out_ready.
- result  out  16·LANES  fp16 products, packed like a.

## Operation
- Per lane, the result is the exact product a·b·2^-FXP_FRAC rounded once to fp16 with round-to-nearest-even. There is no intermediate conversion of b to fp16.
- Datapath per lane:
  - unpack a to sign, exponent and an 11-bit significand with the hidden bit;
  - take |b| as an FXP_WIDTH-bit magnitude, so -2^(FXP_WIDTH-1) is exact;
  - multiply to an (11+FXP_WIDTH)-bit product;
  - leading-one normalise;
  - exponent = ea − FXP_FRAC + (leading-one position − 10);
  - round with guard and sticky bits, renormalise on carry-out, then pack.
- Sign is a.sign XOR b.sign in every case, including zero results.
- Special cases:
  - a subnormal or zero → treated as zero;
  - b = 0 → signed zero;
  - a NaN → 0x7E00;
  - a = ±Inf with b = 0 → 0x7E00;
  - a = ±Inf with b ≠ 0 → ±Inf.
- Underflow: a rounded result below 2^-14 flushes to signed zero. No subnormal outputs are produced.
- Overflow: a rounded exponent above 30 gives ±Inf (0x7C00/0xFC00). See Configuration for the alternative.
- Lanes are fully independent in arithmetic and share control.

## Timing
- Three pipeline stages:
  - S1: unpack, magnitude, special-case classify;
  - S2: significand multiply, exponent add;
  - S3: normalise, round, pack into the output register.
- Latency: 3 cycles from an accepted beat to out_valid with no backpressure. Throughput is 1 beat per cycle.
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv, combinationally.
- When adv is low, every stage register, including its valid bit, holds its value. Bubbles are not collapsed.
- A beat presented while in_ready is low is not accepted. The source holds it.
- result is stable and unchanged while out_valid & ~out_ready. Beat order is preserved.
- Reset:
  - on reset high, out_valid = 0, result = 0, and all stage valids are cleared;
  - in_ready reads 1 in the cycle after reset;
  - beats in flight when reset asserts are discarded and never emitted.
- Simultaneous accept and emit in one cycle are legal and sustain full throughput.

## Configuration
- FP16_FXP_MUL_SATURATE_EN defined: overflow produces max finite ±65504 (0x7BFF/0xFBFF) instead of ±Inf. An Inf input still produces Inf and a NaN input still produces NaN.
- Undefined: overflow produces ±Inf as specified above.

## Test plan
- Basic, LANES=4, FXP_FRAC=0: a = 0x3C00 in all lanes, b = {3, −1, 0, −128} → result = {0x4200, 0xBC00, 0x0000, 0xD800} with out_valid exactly 3 cycles after accept.
- Rounding: a = 0x3C01, b = 3 → 0x4202 (tie, rounds to even). FXP_FRAC=2, a = 0x4000, b = 5 → 0x4100 (2.5).
- Overflow: a = 0x7BFF, b = 2 → 0x7C00 without the macro, 0x7BFF with FP16_FXP_MUL_SATURATE_EN.
- Special values:
  - a = 0x7E00, b = 1 → 0x7E00;
  - a = 0x7C00, b = 0 → 0x7E00;
  - a = 0xFC00, b = −2 → 0x7C00;
  - a = 0x0001, b = 5 → 0x0000.
- Backpressure: stream 6 beats back to back with out_ready low for 5 cycles after the first out_valid. Required: in_ready drops the same cycle; no beat is lost or duplicated; order is preserved; result is held steady while stalled.
- Reset mid-flight: accept 2 beats, assert reset for 1 cycle. Required: out_valid stays 0 and neither beat is ever emitted; a new beat accepted after reset emerges 3 cycles later.
